food_spawner: RTL and testbench

- Sits directly downstream of the pseudo-random point generator. Consumes its free-running randX/randY stream and decides where the next food item goes.
- Samples a candidate, rejects it if it is out of bounds or overlaps any snake segment, and retries until a clear spot is found.
- Holds the committed food position stable for the renderer and collision logic until the food is eaten.
- Scans snake segments one per cycle through a synchronous read port on the snake body memory.

---
 rtl/food_spawner.sv | 200 ++++++++++++++++++++
 tb/tb_food_spawner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/food_spawner.sv
// Food placement: samples random candidates, rejects out-of-bounds or snake-overlapping
// spots, retries, and commits. Optional macro FOOD_GRID_SNAP_EN snaps candidates to the CELL grid.
module food_spawner #(
    parameter int CELL       = 10,
    parameter int H_MAX      = 640,
    parameter int V_MAX      = 480,
    parameter int MAX_LEN    = 64,
    parameter int MAX_TRIES  = 15,
    parameter int FALLBACK_X = 320,
    parameter int FALLBACK_Y = 240
) (
    input  logic                       VGA_clk,
    input  logic                       reset_n,
    input  logic [9:0]                 randX,
    input  logic [8:0]                 randY,
    input  logic                       eaten,
    input  logic [$clog2(MAX_LEN):0]   snake_len,
    output logic [$clog2(MAX_LEN)-1:0] seg_addr,
    input  logic [9:0]                 seg_x,
    input  logic [8:0]                 seg_y,
    output logic [9:0]                 food_x,
    output logic [8:0]                 food_y,
    output logic                       food_valid,
    output logic                       spawn_done,
    output logic                       fallback_used,
    output logic                       busy
);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int LEN_W  = ADDR_W + 1;
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam logic [10:0]      X_LIM   = 11'(H_MAX - CELL);
    localparam logic [10:0]      Y_LIM   = 11'(V_MAX - CELL);
    localparam logic [10:0]      CELL_W  = 11'(CELL);
    localparam logic [TRY_W-1:0] TRY_LIM = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {S_SAMPLE, S_SNAP, S_SCAN, S_COMMIT, S_HOLD} state_t;
    state_t r_state, w_state_next, w_after_decide;

    logic [9:0]       r_cand_x;
    logic [8:0]       r_cand_y;
    logic [LEN_W-1:0] r_len, r_scan_cnt, w_cnt_inc;
    logic [TRY_W-1:0] r_tries, w_tries_inc;
    logic             r_fallback;

    logic        w_decide, w_oob, w_hit, w_reject, w_give_up, w_scan_done;
    logic [10:0] w_dec_x, w_dec_y, w_cx, w_cy, w_sx, w_sy, w_dx, w_dy;

`ifdef FOOD_GRID_SNAP_EN
    // Restoring division by CELL: remainder ends up in r_rem after 7 shifted subtracts.
    logic [10:0] r_rem_x, r_rem_y, w_div;
    logic [2:0]  r_snap_step;
    assign w_div    = CELL_W << (3'd6 - r_snap_step);
    assign w_decide = (r_state == S_SNAP) && (r_snap_step == 3'd7);
    assign w_dec_x  = {1'b0, r_cand_x} - r_rem_x;
    assign w_dec_y  = {2'b0, r_cand_y} - r_rem_y;
`else
    assign w_decide = (r_state == S_SAMPLE);
    assign w_dec_x  = {1'b0, randX};
    assign w_dec_y  = {2'b0, randY};
`endif

    // Segment data returned this cycle belongs to the address issued last cycle.
    assign w_cx = {1'b0, r_cand_x};
    assign w_cy = {2'b0, r_cand_y};
    assign w_sx = {1'b0, seg_x};
    assign w_sy = {2'b0, seg_y};
    assign w_dx = (w_cx >= w_sx) ? (w_cx - w_sx) : (w_sx - w_cx);
    assign w_dy = (w_cy >= w_sy) ? (w_cy - w_sy) : (w_sy - w_cy);

    assign w_hit       = (r_state == S_SCAN) && (r_scan_cnt != '0) && (w_dx < CELL_W) && (w_dy < CELL_W);
    assign w_oob       = (w_dec_x > X_LIM) || (w_dec_y > Y_LIM);
    assign w_reject    = (w_decide && w_oob) || w_hit;
    assign w_tries_inc = r_tries + TRY_W'(1);
    assign w_give_up   = (w_tries_inc == TRY_LIM);
    assign w_scan_done = (r_scan_cnt == r_len);
    assign w_cnt_inc   = r_scan_cnt + LEN_W'(1);

    always_comb begin
        w_after_decide = S_SCAN;
        if (w_oob)
            w_after_decide = w_give_up ? S_COMMIT : S_SAMPLE;
        else if (snake_len == '0)
            w_after_decide = S_COMMIT;
    end

    always_ff @(posedge VGA_clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_SAMPLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_SAMPLE: begin
`ifdef FOOD_GRID_SNAP_EN
                w_state_next = S_SNAP;
`else
                w_state_next = w_after_decide;
`endif
            end
            S_SNAP: begin
                if (w_decide)
                    w_state_next = w_after_decide;
            end
            S_SCAN: begin
                if (w_hit)
                    w_state_next = w_give_up ? S_COMMIT : S_SAMPLE;
                else if (w_scan_done)
                    w_state_next = S_COMMIT;
            end
            S_COMMIT: w_state_next = S_HOLD;
            S_HOLD: begin
                if (eaten)
                    w_state_next = S_SAMPLE;
            end
            default: w_state_next = S_SAMPLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_HOLD);
    end

    always_ff @(posedge VGA_clk or negedge reset_n) begin
        if (!reset_n) begin
            food_x        <= 10'(FALLBACK_X);
            food_y        <= 9'(FALLBACK_Y);
            food_valid    <= 1'b0;
            spawn_done    <= 1'b0;
            fallback_used <= 1'b0;
            seg_addr      <= '0;
            r_tries       <= '0;
            r_cand_x      <= '0;
            r_cand_y      <= '0;
            r_len         <= '0;
            r_scan_cnt    <= '0;
            r_fallback    <= 1'b0;
`ifdef FOOD_GRID_SNAP_EN
            r_rem_x       <= '0;
            r_rem_y       <= '0;
            r_snap_step   <= '0;
`endif
        end else begin
            spawn_done    <= 1'b0;
            fallback_used <= 1'b0;
            case (r_state)
                S_SAMPLE: begin
                    r_cand_x   <= randX;
                    r_cand_y   <= randY;
                    seg_addr   <= '0;
                    r_scan_cnt <= '0;
                    r_len      <= snake_len;
                    r_fallback <= 1'b0;
`ifdef FOOD_GRID_SNAP_EN
                    r_rem_x     <= {1'b0, randX};
                    r_rem_y     <= {2'b0, randY};
                    r_snap_step <= '0;
`endif
                end
`ifdef FOOD_GRID_SNAP_EN
                S_SNAP: begin
                    if (w_decide) begin
                        r_cand_x <= w_dec_x[9:0];
                        r_cand_y <= w_dec_y[8:0];
                        r_len    <= snake_len;
                    end else begin
                        if (r_rem_x >= w_div) r_rem_x <= r_rem_x - w_div;
                        if (r_rem_y >= w_div) r_rem_y <= r_rem_y - w_div;
                        r_snap_step <= r_snap_step + 3'd1;
                    end
                end
`endif
                S_SCAN: begin
                    r_scan_cnt <= w_cnt_inc;
                    if (w_cnt_inc < r_len)
                        seg_addr <= seg_addr + ADDR_W'(1);
                end
                S_COMMIT: begin
                    food_x        <= r_fallback ? 10'(FALLBACK_X) : r_cand_x;
                    food_y        <= r_fallback ? 9'(FALLBACK_Y) : r_cand_y;
                    food_valid    <= 1'b1;
                    spawn_done    <= 1'b1;
                    fallback_used <= r_fallback;
                    r_tries       <= '0;
                end
                S_HOLD: begin
                    if (eaten)
                        food_valid <= 1'b0;
                end
                default: ;
            endcase
            if (w_reject) begin
                r_tries    <= w_tries_inc;
                r_fallback <= w_give_up;
            end
        end
    end
endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: table of spawn scenarios over a fixed snake body
// memory, plus hand-written sequences for retry, ignored eaten, and mid-scan reset.
module tb_food_spawner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] randX = 10'd200;
    logic [8:0] randY = 9'd100;
    logic       eaten = 1'b0;
    logic [6:0] snake_len = 7'd0;
    logic [5:0] seg_addr;
    logic [9:0] seg_x;
    logic [8:0] seg_y;
    logic [9:0] food_x;
    logic [8:0] food_y;
    logic       food_valid, spawn_done, fallback_used, busy;

    logic [9:0] mem_x [64];
    logic [8:0] mem_y [64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Snake body memory with one-cycle registered read.
    always @(posedge clk) begin
        seg_x <= mem_x[seg_addr];
        seg_y <= mem_y[seg_addr];
    end

    food_spawner dut (
        .VGA_clk(clk), .reset_n(rst_n), .randX(randX), .randY(randY), .eaten(eaten),
        .snake_len(snake_len), .seg_addr(seg_addr), .seg_x(seg_x), .seg_y(seg_y),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .spawn_done(spawn_done),
        .fallback_used(fallback_used), .busy(busy)
    );

    typedef struct {
        int len; int rx; int ry; int fx; int fy; int fb; int lat; int noscan;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_spawn(input int start, output int cnt, output int max_addr);
        cnt = start;
        max_addr = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            cnt++;
            if (int'(seg_addr) > max_addr) max_addr = int'(seg_addr);
            if (spawn_done) return;
        end
        cnt = -1;
    endtask

    task automatic pulse_eaten();
        eaten = 1'b1;
        tick();
        eaten = 1'b0;
    endtask

    initial begin
        int lat, maxa, extra;

        for (int i = 0; i < 64; i++) begin
            mem_x[i] = 10'(10 * i);
            mem_y[i] = 9'd300;
        end
        //          len  rx   ry   fx   fy  fb  lat noscan
        vecs[0]  = '{0,  200, 100, 200, 100, 0,   2, 0};
        vecs[1]  = '{1,  300, 100, 300, 100, 0,   4, 0};
        vecs[2]  = '{5,  100, 291, 100, 291, 0,   8, 0};
        vecs[3]  = '{5,   45, 309, 320, 240, 1, 106, 0};
        vecs[4]  = '{3,  635, 100, 320, 240, 1,  16, 1};
        vecs[5]  = '{3,  100, 471, 320, 240, 1,  16, 1};
        vecs[6]  = '{0,  630, 470, 630, 470, 0,   2, 0};
        vecs[7]  = '{3,   30, 295,  30, 295, 0,   6, 0};
        vecs[8]  = '{11, 100, 295, 320, 240, 1, 196, 0};
        vecs[9]  = '{40, 500, 100, 500, 100, 0,  43, 0};
        vecs[10] = '{64, 300, 250, 300, 250, 0,  67, 0};

        // Reset values, then the automatic first placement.
        tick();
        tick();
        chk("rst_food_x", food_x, 320);
        chk("rst_food_y", food_y, 240);
        chk("rst_valid", food_valid, 0);
        chk("rst_spawn", spawn_done, 0);
        chk("rst_busy", busy, 1);
        rst_n = 1'b1;
        wait_spawn(0, lat, maxa);
        chk("first_latency", lat, 2);
        chk("first_food_x", food_x, 200);
        chk("first_food_y", food_y, 100);
        chk("first_valid", food_valid, 1);
        $display("first spawn: food=(%0d,%0d) lat=%0d", food_x, food_y, lat);
        tick();

        for (int v = 0; v < 11; v++) begin
            snake_len = 7'(vecs[v].len);
            randX = 10'(vecs[v].rx);
            randY = 9'(vecs[v].ry);
            pulse_eaten();
            chk("valid_drop", food_valid, 0);
            chk("busy_after_eaten", busy, 1);
            wait_spawn(0, lat, maxa);
            chk("latency", lat, vecs[v].lat);
            chk("food_x", food_x, vecs[v].fx);
            chk("food_y", food_y, vecs[v].fy);
            chk("fallback_used", fallback_used, vecs[v].fb);
            chk("valid_set", food_valid, 1);
            chk("busy_hold", busy, 0);
            if (vecs[v].noscan != 0) chk("seg_addr_idle", maxa, 0);
            $display("vec %0d: len=%0d cand=(%0d,%0d) food=(%0d,%0d) fb=%0d lat=%0d",
                     v, vecs[v].len, vecs[v].rx, vecs[v].ry, food_x, food_y, fallback_used, lat);
            tick();
            chk("pulse_end", {spawn_done, fallback_used}, 0);
        end

        // One overlap reject followed by a clear candidate.
        snake_len = 7'd1;
        mem_x[0] = 10'd200;
        mem_y[0] = 9'd100;
        randX = 10'd205;
        randY = 9'd95;
        pulse_eaten();
        tick();
        randX = 10'd300;
        randY = 9'd100;
        wait_spawn(1, lat, maxa);
        chk("retry_latency", lat, 7);
        chk("retry_food_x", food_x, 300);
        chk("retry_food_y", food_y, 100);
        chk("retry_fb", fallback_used, 0);
        $display("retry spawn: food=(%0d,%0d) lat=%0d", food_x, food_y, lat);
        mem_x[0] = 10'd0;
        mem_y[0] = 9'd300;
        tick();

        // Full 15-try budget after the retry proves tries were cleared.
        snake_len = 7'd3;
        randX = 10'd635;
        randY = 9'd100;
        pulse_eaten();
        wait_spawn(0, lat, maxa);
        chk("tries_clear_latency", lat, 16);
        chk("tries_clear_fb", fallback_used, 1);
        chk("tries_clear_food_x", food_x, 320);
        $display("fallback spawn: food=(%0d,%0d) lat=%0d", food_x, food_y, lat);
        tick();

        // eaten during SCAN must not trigger a second respawn.
        snake_len = 7'd40;
        randX = 10'd500;
        randY = 9'd100;
        pulse_eaten();
        repeat (5) tick();
        pulse_eaten();
        wait_spawn(6, lat, maxa);
        chk("scan_eaten_latency", lat, 43);
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (spawn_done) extra++;
        end
        chk("scan_eaten_extra", extra, 0);
        chk("scan_eaten_valid", food_valid, 1);
        $display("ignored eaten: food=(%0d,%0d) extra_spawns=%0d", food_x, food_y, extra);

        // Asynchronous reset in the middle of a long scan.
        randX = 10'd400;
        randY = 9'd50;
        pulse_eaten();
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_food_x", food_x, 320);
        chk("mid_rst_food_y", food_y, 240);
        chk("mid_rst_valid", food_valid, 0);
        chk("mid_rst_seg_addr", seg_addr, 0);
        chk("mid_rst_busy", busy, 1);
        tick();
        snake_len = 7'd0;
        randX = 10'd200;
        randY = 9'd100;
        rst_n = 1'b1;
        wait_spawn(0, lat, maxa);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_food_x", food_x, 200);
        chk("post_rst_food_y", food_y, 100);
        chk("post_rst_fb", fallback_used, 0);
        $display("reset respawn: food=(%0d,%0d) lat=%0d", food_x, food_y, lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
